// File: rtl/fifo_rr_arb.sv
// fifo_rr_arb: round-robin arbiter that merges N valid/ready requester streams into one
// registered FIFO write port, tagging each beat with its source index.
// Optional macro PKT_LOCK_EN: when defined, a grant is held until the grantee's i_last beat
// (packet mode). When undefined, a grant ends after MAX_BURST beats or when the grantee
// drops i_val (burst mode).
module fifo_rr_arb #(
    parameter int unsigned N         = 4,
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MAX_BURST = 16,
    localparam int unsigned SW       = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [N-1:0]     i_val,
    output logic [N-1:0]     i_rdy,
    input  logic [N*WIDTH-1:0] i_data,
    input  logic [N-1:0]     i_last,
    output logic             o_val,
    input  logic             o_rdy,
    output logic [WIDTH-1:0] o_data,
    output logic             o_last,
    output logic [SW-1:0]    o_src,
    output logic             o_busy
);

    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e         state_q, state_d;
    logic [SW-1:0]  ptr_q, ptr_d;
    logic [SW-1:0]  grant_q, grant_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic             o_val_q;
    logic [WIDTH-1:0] o_data_q;
    logic             o_last_q;
    logic [SW-1:0]    o_src_q;

    logic             sel_val;
    logic [WIDTH-1:0] sel_data;
    logic             pick_found;
    logic [SW-1:0]    pick_idx;
    logic             out_free;
    logic             busy;
    logic             accept;
    logic             last_beat;
    logic             release_grant;

`ifdef PKT_LOCK_EN
    logic             sel_last;
`else
    // i_last has no meaning in burst mode; folded here so it is not left dangling.
    logic             unused_last;
    assign unused_last = ^i_last;
`endif

    // Select the current grantee's valid, data and last flag.
    always_comb begin
        sel_val  = 1'b0;
        sel_data = '0;
`ifdef PKT_LOCK_EN
        sel_last = 1'b0;
`endif
        for (int unsigned k = 0; k < N; k++) begin
            if (grant_q == SW'(k)) begin
                sel_val  = i_val[k];
                sel_data = i_data[k*WIDTH +: WIDTH];
`ifdef PKT_LOCK_EN
                sel_last = i_last[k];
`endif
            end
        end
    end

    // Round-robin pick: first valid requester searching ptr+1, ptr+2, ... modulo N.
    always_comb begin
        int unsigned cand;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            for (int unsigned k = 0; k < N; k++) begin
                if (!pick_found && (cand == k) && i_val[k]) begin
                    pick_found = 1'b1;
                    pick_idx   = SW'(k);
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= StIdle;
            ptr_q   <= SW'(N - 1);
            grant_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state: arbitrate in idle, count beats and detect release while granted.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    cnt_d   = '0;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (accept) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (release_grant) begin
                    // Just-served requester drops to lowest priority next round.
                    ptr_d   = grant_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: handshake toward requesters and the release decision.
    always_comb begin
        busy     = (state_q == StGrant);
        out_free = ~o_val_q | o_rdy;
        accept   = busy & sel_val & out_free;
`ifdef PKT_LOCK_EN
        last_beat     = sel_last;
        release_grant = accept & sel_last;
`else
        last_beat     = (cnt_q == CW'(MAX_BURST - 1));
        // A grantee that goes idle gives up the grant without producing a beat.
        release_grant = (accept & last_beat) | (busy & ~sel_val);
`endif
        i_rdy = '0;
        for (int unsigned k = 0; k < N; k++) begin
            i_rdy[k] = busy & out_free & (grant_q == SW'(k));
        end
    end

    // Output stage: load on an accepted beat, drain when the FIFO takes it, else hold.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            o_val_q  <= 1'b0;
            o_data_q <= '0;
            o_last_q <= 1'b0;
            o_src_q  <= '0;
        end else if (accept) begin
            o_val_q  <= 1'b1;
            o_data_q <= sel_data;
            o_last_q <= last_beat;
            o_src_q  <= grant_q;
        end else if (o_val_q && o_rdy) begin
            o_val_q  <= 1'b0;
        end
    end

    assign o_val  = o_val_q;
    assign o_data = o_data_q;
    assign o_last = o_last_q;
    assign o_src  = o_src_q;
    assign o_busy = (state_q == StGrant);

endmodule
